// File: rtl/raster_pkg.sv
// Shared types for the raster triangle dispatcher: vertex layout and the
// dispatcher state encoding.
package raster_pkg;

  localparam int DATAWIDTH = 12;

  typedef struct packed {
    logic signed [DATAWIDTH-1:0] x;
    logic signed [DATAWIDTH-1:0] y;
    logic signed [DATAWIDTH-1:0] z;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RESULT,
    HANDOFF,
    DRAIN,
    RESOLVE
  } dispatch_state_t;

endpackage

// File: rtl/raster_triangle_dispatcher_if.sv
// Upstream, frontend, backend and status signals of the dispatcher.
// master = dispatcher side, slave = surrounding pipeline.
interface raster_triangle_dispatcher_if #(
  parameter int CNT_WIDTH = 16
);
  import raster_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  vertex_t              in_v0, in_v1, in_v2;
  logic                 fe_ready;
  logic                 fe_triangle_dv;
  vertex_t              fe_v0, fe_v1, fe_v2;
  logic                 fe_o_dv;
  logic                 fe_next;
  logic                 bk_ready;
  logic                 bk_start;
  logic                 frame_done;
  logic                 busy;
  logic                 timeout_err;
  logic [CNT_WIDTH-1:0] cnt_issued, cnt_drawn, cnt_culled;

  modport master (
    input  in_valid, in_last, in_v0, in_v1, in_v2, fe_ready, fe_o_dv, bk_ready,
    output in_ready, fe_triangle_dv, fe_v0, fe_v1, fe_v2, fe_next, bk_start,
           frame_done, busy, timeout_err, cnt_issued, cnt_drawn, cnt_culled
  );

  modport slave (
    output in_valid, in_last, in_v0, in_v1, in_v2, fe_ready, fe_o_dv, bk_ready,
    input  in_ready, fe_triangle_dv, fe_v0, fe_v1, fe_v2, fe_next, bk_start,
           frame_done, busy, timeout_err, cnt_issued, cnt_drawn, cnt_culled
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/raster_triangle_dispatcher.sv
// Issues one triangle at a time to the rasterizer frontend, classifies it as
// drawn or culled, hands drawn ones to the backend and keeps frame statistics.
module raster_triangle_dispatcher
  import raster_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  raster_triangle_dispatcher_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  dispatch_state_t state, state_nxt;
  logic            last_r;
  logic [WD_W-1:0] wd;
  logic            timeout_err_r;
  vertex_t         v0_r, v1_r, v2_r;

  logic in_ready, accept, fe_dv, fe_next, bk_start, frame_done, wd_fire;
  logic inc_issued, inc_drawn, inc_culled;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    fe_dv      = 1'b0;
    fe_next    = 1'b0;
    bk_start   = 1'b0;
    frame_done = 1'b0;
    wd_fire    = 1'b0;
    inc_issued = 1'b0;
    inc_drawn  = 1'b0;
    inc_culled = 1'b0;
    case (state)
      IDLE: begin
        in_ready = bus.fe_ready && !rst;
        if (bus.in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        fe_dv      = 1'b1;
        inc_issued = 1'b1;
        state_nxt  = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        // A result beats a simultaneous return to idle.
        if (bus.fe_o_dv) begin
          state_nxt = HANDOFF;
        end else if (bus.fe_ready) begin
          inc_culled = 1'b1;
          state_nxt  = RESOLVE;
        end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          wd_fire    = 1'b1;
          inc_culled = 1'b1;
          state_nxt  = RESOLVE;
        end
      end
      HANDOFF: begin
        if (bus.bk_ready) begin
          bk_start  = 1'b1;
          fe_next   = 1'b1;
          inc_drawn = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = RESOLVE;
      RESOLVE: begin
        frame_done = last_r;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the vertex copies are ordinary registers (not a memory array), so
  // they are cleared on reset together with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_r        <= 1'b0;
      wd            <= '0;
      timeout_err_r <= 1'b0;
      v0_r          <= '0;
      v1_r          <= '0;
      v2_r          <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        v0_r   <= bus.in_v0;
        v1_r   <= bus.in_v1;
        v2_r   <= bus.in_v2;
        last_r <= bus.in_last;
      end
      if (state == ISSUE) begin
        wd <= '0;
      end else if (state == WAIT_RESULT) begin
        wd <= wd + WD_W'(1);
      end
      if (wd_fire) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  logic [CNT_WIDTH-1:0] cnt_issued, cnt_drawn, cnt_culled;

  // Statistics restart on the edge that ends the frame_done cycle.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_issued (
    .clk(clk), .rst(rst), .inc(inc_issued), .clr(frame_done), .q(cnt_issued)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_drawn (
    .clk(clk), .rst(rst), .inc(inc_drawn), .clr(frame_done), .q(cnt_drawn)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_culled (
    .clk(clk), .rst(rst), .inc(inc_culled), .clr(frame_done), .q(cnt_culled)
  );

  assign bus.in_ready       = in_ready;
  assign bus.fe_triangle_dv = fe_dv;
  assign bus.fe_v0          = v0_r;
  assign bus.fe_v1          = v1_r;
  assign bus.fe_v2          = v2_r;
  assign bus.fe_next        = fe_next;
  assign bus.bk_start       = bk_start;
  assign bus.frame_done     = frame_done;
  assign bus.busy           = (state != IDLE);
  assign bus.timeout_err    = timeout_err_r;
  assign bus.cnt_issued     = cnt_issued;
  assign bus.cnt_drawn      = cnt_drawn;
  assign bus.cnt_culled     = cnt_culled;

endmodule
